// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM states, line mux selects, framing bit levels.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b011,
      PARITY = 3'b010,
      STOP   = 3'b110,
      STOP2  = 3'b111
   } state_e;

   typedef enum logic [1:0] {
      SEL_START = 2'd0,
      SEL_DATA  = 2'd1,
      SEL_PAR   = 2'd2,
      SEL_STOP  = 2'd3
   } sel_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Frame parity bit: XOR-reduce of the data byte, inverted when odd parity is selected.
module uart_parity_calc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             par_typ_i,
   output logic             par_bit_o
);

   assign par_bit_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop and drives the registered TX line.
// Build option: define UART_TX_TWO_STOP_EN to append a second stop bit to every frame.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit selected onto the line mux
// DATA   | serializer enabled, ser_data selected, leave on ser_done
// PARITY | latched parity bit selected
// STOP   | stop bit selected
// STOP2  | second stop bit (UART_TX_TWO_STOP_EN only)
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             Data_Valid,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   input  logic             ser_data,
   input  logic             ser_done,
   output logic             ser_en,
   output logic             busy,
   output logic             TX_OUT
);

   state_e state_q;
   logic   par_en_q;
   logic   par_bit_q;
   logic   tx_q;
   logic   tx_d;
   logic   par_calc;
   sel_e   sel;

   uart_parity_calc #(
      .WIDTH(WIDTH)
   ) u_parity (
      .data_i   (P_DATA),
      .par_typ_i(PAR_TYP),
      .par_bit_o(par_calc)
   );

   assign busy   = (state_q != IDLE);
   assign ser_en = (state_q == DATA);
   assign TX_OUT = tx_q;

   always_comb begin
      sel = SEL_STOP;
      case (state_q)
         START:   sel = SEL_START;
         DATA:    sel = SEL_DATA;
         PARITY:  sel = SEL_PAR;
         default: sel = SEL_STOP;
      endcase
   end

   always_comb begin
      tx_d = STOP_BIT;
      case (sel)
         SEL_START: tx_d = START_BIT;
         SEL_DATA:  tx_d = ser_data;
         SEL_PAR:   tx_d = par_bit_q;
         default:   tx_d = STOP_BIT;
      endcase
   end

   // The line register follows the mux every cycle, so each bit lags its state by one clock.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         tx_q      <= STOP_BIT;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         tx_q <= tx_d;
         case (state_q)
            IDLE: begin
               if (Data_Valid) begin
                  state_q   <= START;
                  par_en_q  <= PAR_EN;
                  par_bit_q <= par_calc;
               end
            end
            START:  state_q <= DATA;
            DATA: begin
               if (ser_done) state_q <= par_en_q ? PARITY : STOP;
            end
            PARITY: state_q <= STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:   state_q <= STOP2;
            STOP2:  state_q <= IDLE;
`else
            STOP:   state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: behavioural serializer plus a per-cycle scoreboard of {TX_OUT, busy, ser_en}.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

   localparam int WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
   localparam bit TWO_STOP = 1'b1;
`else
   localparam bit TWO_STOP = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] P_DATA;
   logic             Data_Valid;
   logic             PAR_EN;
   logic             PAR_TYP;
   logic             ser_data;
   logic             ser_done;
   logic             ser_en;
   logic             busy;
   logic             TX_OUT;

   typedef logic [2:0] exp_t;   // {TX_OUT, busy, ser_en}
   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_chk  = 0;

   always #5 CLK = ~CLK;

   uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .ser_data  (ser_data),
      .ser_done  (ser_done),
      .ser_en    (ser_en),
      .busy      (busy),
      .TX_OUT    (TX_OUT)
   );

   // Serializer model: loads on Data_Valid && !busy, shifts LSB first while enabled.
   logic [7:0] ser_q;
   logic [2:0] cnt_q;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ser_q <= '0;
         cnt_q <= '0;
      end else if (Data_Valid && !busy) begin
         ser_q <= P_DATA;
         cnt_q <= '0;
      end else if (ser_en) begin
         cnt_q <= cnt_q + 3'd1;
      end
   end
   assign ser_data = ser_q[cnt_q];
   assign ser_done = ser_en && (cnt_q == 3'd7);

   // Expected observations for cycles N+1 onward after acceptance at cycle N.
   function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
      exp_q.push_back(3'b110);
      exp_q.push_back(3'b011);
      for (int i = 0; i < 7; i++) exp_q.push_back({d[i], 2'b11});
      exp_q.push_back({d[7], 2'b10});
      if (pe) exp_q.push_back({(^d) ^ pt, 2'b10});
      exp_q.push_back({1'b1, TWO_STOP, 1'b0});
      if (TWO_STOP) exp_q.push_back(3'b100);
   endfunction

   task automatic test_reset();
      exp_t e;
      RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      exp_q.delete();
      repeat (23) exp_q.push_back(3'b100);
      for (int k = 1; k <= 23; k++) begin
         @(negedge CLK);
         e = exp_q.pop_front();
         n_chk++;
         if ({TX_OUT, busy, ser_en} !== e)
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, {TX_OUT, busy, ser_en}, e);
         else n_pass++;
         if (k == 3) RST = 1'b1;
      end
   endtask

   task automatic test_frame(input string name, input logic [7:0] d, input logic pe, input logic pt);
      exp_t e;
      int   n;
      exp_q.delete();
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
      push_frame(d, pe, pt);
      exp_q.push_back(3'b100);
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            // Mid-frame input changes must not alter the frame in flight.
            Data_Valid = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
         end
         e = exp_q.pop_front();
         n_chk++;
         if ({TX_OUT, busy, ser_en} !== e)
            $display("FAIL %s cyc=N+%0d got=%b exp=%b", name, k, {TX_OUT, busy, ser_en}, e);
         else n_pass++;
      end
   endtask

   task automatic test_ignore();
      exp_t e;
      int   n;
      exp_q.delete();
      @(negedge CLK);
      P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      push_frame(8'hA5, 1'b0, 1'b0);
      repeat (3) exp_q.push_back(3'b100);
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK);
         if (k == 1) Data_Valid = 1'b0;
         if (k == 5) begin Data_Valid = 1'b1; P_DATA = 8'hFF; end
         if (k == 6) Data_Valid = 1'b0;
         e = exp_q.pop_front();
         n_chk++;
         if ({TX_OUT, busy, ser_en} !== e)
            $display("FAIL ignore_busy cyc=N+%0d got=%b exp=%b", k, {TX_OUT, busy, ser_en}, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   n;
      int   len1;
      exp_q.delete();
      @(negedge CLK);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      push_frame(8'h55, 1'b0, 1'b0);
      len1 = exp_q.size();
      push_frame(8'h0F, 1'b0, 1'b0);
      repeat (2) exp_q.push_back(3'b100);
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK);
         if (k == 1) P_DATA = 8'h0F;
         if (k == len1 + 1) Data_Valid = 1'b0;
         e = exp_q.pop_front();
         n_chk++;
         if ({TX_OUT, busy, ser_en} !== e)
            $display("FAIL back_to_back cyc=N+%0d got=%b exp=%b", k, {TX_OUT, busy, ser_en}, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      exp_q.delete();
      @(negedge CLK);
      P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      push_frame(8'hC3, 1'b1, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         if (k == 1) Data_Valid = 1'b0;
         e = exp_q.pop_front();
         n_chk++;
         if ({TX_OUT, busy, ser_en} !== e)
            $display("FAIL pre_reset cyc=N+%0d got=%b exp=%b", k, {TX_OUT, busy, ser_en}, e);
         else n_pass++;
      end
      exp_q.delete();
      RST = 1'b0;
      #1;
      n_chk++;
      if ({TX_OUT, busy, ser_en} !== 3'b100)
         $display("FAIL reset_abort got=%b exp=100", {TX_OUT, busy, ser_en});
      else n_pass++;
      @(negedge CLK);
      n_chk++;
      if ({TX_OUT, busy, ser_en} !== 3'b100)
         $display("FAIL reset_hold got=%b exp=100", {TX_OUT, busy, ser_en});
      else n_pass++;
      RST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_frame("a5_nopar", 8'hA5, 1'b0, 1'b0);
      test_frame("07_even", 8'h07, 1'b1, 1'b0);
      test_frame("07_odd", 8'h07, 1'b1, 1'b1);
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      test_frame("3c_after_reset", 8'h3C, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
